// File: rtl/sinc_uart_tx_pkg.sv
// rtl/sinc_uart_tx_pkg.sv - shared types and byte selection for the sinc2 UART sender (option: SINC_UART_SYNC_EN)
package sigdel_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         SAMPLE_W  = 16;

`ifdef SINC_UART_SYNC_EN
  localparam logic [1:0] LAST_IDX = 2'd2;
`else
  localparam logic [1:0] LAST_IDX = 2'd1;
`endif

  // Byte sent at position idx of a frame; high byte always precedes low byte
  function automatic logic [7:0] frame_byte(input logic [SAMPLE_W-1:0] s, input logic [1:0] idx);
`ifdef SINC_UART_SYNC_EN
    case (idx)
      2'd0:    return SYNC_BYTE;
      2'd1:    return s[15:8];
      default: return s[7:0];
    endcase
`else
    return (idx == 2'd0) ? s[15:8] : s[7:0];
`endif
  endfunction

endpackage

// File: rtl/sinc_uart_tx_if.sv
// rtl/sinc_uart_tx_if.sv - sample input and UART status bundle
interface sinc_uart_tx_if;
  import sigdel_pkg::*;

  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                clr_ovr;
  logic                tx;
  logic                busy;
  logic                hold_full;
  logic                overrun;

  modport master (output sample_in, sample_valid, clr_ovr,
                  input  tx, busy, hold_full, overrun);
  modport slave  (input  sample_in, sample_valid, clr_ovr,
                  output tx, busy, hold_full, overrun);
endinterface

// File: rtl/sinc_uart_tx_byte.sv
// rtl/sinc_uart_tx_byte.sv - single 8N1 byte serialiser with baud and bit counters
module uart_byte_tx
  import sigdel_pkg::*;
#(
  parameter int BAUD_DIV = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  uart_state_t r_state, w_state_nxt;
  logic [15:0] r_baud,  w_baud_nxt;
  logic [2:0]  r_bit,   w_bit_nxt;
  logic [7:0]  r_data,  w_data_nxt;
  logic        r_tx,    w_tx_nxt;
  logic        w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);
  // done is combinational so a following byte can start on the same edge the stop bit ends
  assign done       = (r_state == STOP) && w_baud_end;
  assign tx         = r_tx;

  // State and counter registers; tx returns high at once on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_data  <= w_data_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next state: each of START, 8 x DATA and STOP lasts one full baud period
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_baud_end ? 16'd0 : r_baud + 16'd1;
    w_bit_nxt   = r_bit;
    w_data_nxt  = r_data;
    w_tx_nxt    = r_tx;
    case (r_state)
      IDLE: begin
        w_baud_nxt = 16'd0;
        w_tx_nxt   = 1'b1;
        if (start) begin
          w_state_nxt = START;
          w_data_nxt  = data;
          w_tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (w_baud_end) begin
          w_state_nxt = DATA;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_data[0];
        end
      end
      DATA: begin
        if (w_baud_end) begin
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_nxt  = r_bit + 3'd1;
            w_data_nxt = r_data >> 1;
            w_tx_nxt   = r_data[1];
          end
        end
      end
      STOP: begin
        if (w_baud_end) begin
          if (start) begin
            w_state_nxt = START;
            w_data_nxt  = data;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/sinc_uart_tx.sv
// rtl/sinc_uart_tx.sv - double-buffered sinc2 sample to UART 8N1 sender (option: SINC_UART_SYNC_EN)
module sinc_uart_tx
  import sigdel_pkg::*;
#(
  parameter int BAUD_DIV = 87
) (
  input  logic           clk,
  input  logic           rst_n,
  sinc_uart_tx_if.slave  bus
);

  logic [SAMPLE_W-1:0] r_hold;
  logic [SAMPLE_W-1:0] r_frame;
  logic                r_hold_full;
  logic                r_ovr;
  logic                r_busy;
  logic [1:0]          r_idx;

  logic                w_load;
  logic                w_done;
  logic                w_more;
  logic                w_start;
  logic                w_accept;
  logic                w_drop;
  logic                w_tx;
  logic [7:0]          w_byte;

  // Leaving IDLE consumes the hold register, so it can accept a sample in that same cycle
  assign w_load   = !r_busy && r_hold_full;
  assign w_more   = (r_idx != LAST_IDX);
  assign w_start  = w_load || (w_done && w_more);
  assign w_accept = bus.sample_valid && (!r_hold_full || w_load);
  assign w_drop   = bus.sample_valid && r_hold_full && !w_load;
  assign w_byte   = w_load ? frame_byte(r_hold, 2'd0) : frame_byte(r_frame, r_idx + 2'd1);

  // Holding register and sticky overrun (a set beats a same-cycle clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_ovr       <= 1'b0;
    end else begin
      if (w_accept) r_hold <= bus.sample_in;
      if (w_accept)    r_hold_full <= 1'b1;
      else if (w_load) r_hold_full <= 1'b0;
      if (w_drop)           r_ovr <= 1'b1;
      else if (bus.clr_ovr) r_ovr <= 1'b0;
    end
  end

  // Byte sequencing: frame buffer, byte index and the IDLE/active flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
      r_idx   <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      if (w_load) begin
        r_frame <= r_hold;
        r_idx   <= 2'd0;
        r_busy  <= 1'b1;
      end else if (w_done) begin
        if (w_more) r_idx  <= r_idx + 2'd1;
        else        r_busy <= 1'b0;
      end
    end
  end

  uart_byte_tx #(.BAUD_DIV(BAUD_DIV)) u_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .data  (w_byte),
    .tx    (w_tx),
    .done  (w_done)
  );

  assign bus.tx        = w_tx;
  assign bus.busy      = r_busy;
  assign bus.hold_full = r_hold_full;
  assign bus.overrun   = r_ovr;

endmodule

// File: tb/tb_sinc_uart_tx.sv
// tb/tb_sinc_uart_tx.sv - scoreboard bench for sinc_uart_tx
module tb_sinc_uart_tx;

  localparam int BD = 4;
`ifdef SINC_UART_SYNC_EN
  localparam int NBYTES = 3;
`else
  localparam int NBYTES = 2;
`endif
  localparam int BUSY_CYC = NBYTES * 10 * BD;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sinc_uart_tx_if bus ();

  sinc_uart_tx #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_sample(input logic [15:0] s);
`ifdef SINC_UART_SYNC_EN
    exp_q.push_back(8'hA5);
`endif
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
  endtask

  // One-cycle strobe; returns at the negedge after the capturing edge
  task automatic strobe(input logic [15:0] v, input bit push, input bit clr);
    @(negedge clk);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    bus.clr_ovr      = clr;
    if (push) push_sample(v);
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.clr_ovr      = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    bus.clr_ovr = 1'b1;
    @(negedge clk);
    bus.clr_ovr = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((bus.busy || bus.hold_full) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) check("wait_idle_timeout", 1, 0);
    repeat (4) @(negedge clk);
  endtask

  // Line monitor: decodes 8N1 bytes at mid-bit and compares against the scoreboard
  int         m_cnt;
  bit         m_active = 1'b0;
  logic [7:0] m_byte;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (bus.tx === 1'b0) begin
        m_active = 1'b1;
        m_cnt    = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt == BD / 2) check("start_bit", bus.tx, 0);
      for (int i = 0; i < 8; i++)
        if (m_cnt == BD / 2 + BD * (i + 1)) m_byte[i] = bus.tx;
      if (m_cnt == BD / 2 + 9 * BD) begin
        check("stop_bit", bus.tx, 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none", m_byte);
        end else begin
          check("byte", m_byte, exp_q.pop_front());
        end
        m_active = 1'b0;
      end
    end
  end

  initial begin
    int n;
    rst_n            = 1'b0;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.clr_ovr      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", {bus.tx, bus.busy, bus.hold_full, bus.overrun}, 4'b1000);
    rst_n = 1'b1;

    // Quiet line with no strobes
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("idle_line", {bus.tx, bus.busy, bus.hold_full, bus.overrun}, 4'b1000);
    end

    // Single sample: latency and busy width
    strobe(16'h12C5, 1, 0);
    check("hold_after_E", bus.hold_full, 1);
    check("tx_high_after_E", bus.tx, 1);
    @(negedge clk);
    check("tx_low_after_E1", bus.tx, 0);
    check("busy_after_E1", bus.busy, 1);
    check("hold_free_after_E1", bus.hold_full, 0);
    n = 1;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      if (bus.busy) n++;
    end
    check("busy_cycles", n, BUSY_CYC);
    wait_idle(1000);
    check("ovr_single", bus.overrun, 0);

    // Two samples back to back: one IDLE cycle between frames
    strobe(16'h8001, 1, 0);
    repeat (8) @(negedge clk);
    strobe(16'h7FFE, 1, 0);
    n = 0;
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_gap", n, 1);
    wait_idle(1000);
    check("ovr_b2b", bus.overrun, 0);

    // Three strobes: third is dropped
    strobe(16'h0001, 1, 0);
    repeat (3) @(negedge clk);
    strobe(16'h0002, 1, 0);
    repeat (3) @(negedge clk);
    strobe(16'h0003, 0, 0);
    check("ovr_set", bus.overrun, 1);
    wait_idle(1000);
    check("ovr_sticky", bus.overrun, 1);
    clr_pulse();
    check("ovr_cleared", bus.overrun, 0);

    // Overrun set and clear in the same cycle: set wins
    strobe(16'h1111, 1, 0);
    repeat (3) @(negedge clk);
    strobe(16'h2222, 1, 0);
    repeat (3) @(negedge clk);
    strobe(16'h3333, 0, 1);
    check("ovr_set_beats_clr", bus.overrun, 1);
    wait_idle(1000);
    clr_pulse();
    check("ovr_cleared2", bus.overrun, 0);

    // Reset during high-byte DATA with hold full and overrun set
    strobe(16'h5A3C, 0, 0);
`ifdef SINC_UART_SYNC_EN
    repeat (10 * BD) @(negedge clk);
`endif
    repeat (2) @(negedge clk);
    strobe(16'h6666, 0, 0);
    repeat (2) @(negedge clk);
    strobe(16'h7777, 0, 0);
    check("pre_reset_flags", {bus.busy, bus.hold_full, bus.overrun}, 3'b111);
    check("pre_reset_tx_data", bus.tx, 0);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {bus.tx, bus.busy, bus.hold_full, bus.overrun}, 4'b1000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    strobe(16'hABCD, 1, 0);
    wait_idle(1000);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
